alu_arith_arbiter: RTL

- Shares one add/sub arithmetic datapath (Y = A+B or A−B, plus a carry/borrow flag) among NREQ requesters.
- Round-robin grant; valid/ready request handshake; registered per-requester response with backpressure.
- Sits between the execute-stage clients (address generation, branch compare, main ALU path) and the single shared adder/subtracter instance.

---
 rtl/alu_arith_arbiter.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_arith_arbiter.sv
// alu_arith_arbiter
// Round-robin arbiter in front of one shared add/sub datapath.
// Requesters use a valid/ready handshake to submit A, B and op. The winner
// is granted for one cycle, its operands are latched, the result is
// computed, and the result is held on a registered response until the
// owner accepts it.
// Optional statistics outputs (grant_cnt, stall_cnt) are built only when
// the macro ALU_ARB_STATS_EN is defined.

module alu_arith_arbiter #(
    parameter int BITS = 32,
    parameter int NREQ = 4,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*BITS-1:0] req_a,
    input  logic [NREQ*BITS-1:0] req_b,
    input  logic [NREQ-1:0]      req_op,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [BITS-1:0]      rsp_y,
    output logic                 rsp_cb,
    output logic                 busy
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]   grant_cnt,
    output logic [15:0]          stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        EXEC  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [IDXW-1:0]   rr_ptr;
    logic [IDXW-1:0]   owner_p0;
    logic [NREQ-1:0]   owner_oh;

    logic [IDXW-1:0]   pick_idx;
    logic [IDXW-1:0]   cand;
    logic              any_valid;
    logic              rsp_accept;

    logic [BITS-1:0]   sel_a;
    logic [BITS-1:0]   sel_b;
    logic              sel_op;

    logic [BITS-1:0]   a_p1;
    logic [BITS-1:0]   b_p1;
    logic              op_p1;
    logic [BITS:0]     sum_p1;

    // The shared datapath: the bit above the result is the carry-out for an
    // add and the borrow for a subtract (a (BITS+1)-bit A-B goes negative
    // exactly when A < B unsigned).
    function automatic logic [BITS:0] addsub(input logic [BITS-1:0] a,
                                             input logic [BITS-1:0] b,
                                             input logic            sub);
        logic [BITS:0] r;
        if (sub) begin
            r = {1'b0, a} - {1'b0, b};
        end else begin
            r = {1'b0, a} + {1'b0, b};
        end
        return r;
    endfunction

    // Next index after the owner, wrapping for any NREQ (not only powers of two).
    function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] idx);
        logic [IDXW-1:0] n;
        if (idx == IDXW'(NREQ - 1)) begin
            n = '0;
        end else begin
            n = idx + IDXW'(1);
        end
        return n;
    endfunction

    assign any_valid  = |req_valid;
    assign owner_oh   = NREQ'(1) << owner_p0;
    assign rsp_accept = |(rsp_ready & owner_oh);

    // Round-robin pick: scan from rr_ptr downward in priority so the
    // closest valid requester at or after rr_ptr is the last one written.
    always_comb begin
        pick_idx = rr_ptr;
        cand     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IDXW'((int'(rr_ptr) + k) % NREQ);
            if (req_valid[cand]) begin
                pick_idx = cand;
            end
        end
    end

    // Operand mux for the registered owner.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_p0 == IDXW'(i)) begin
                sel_a  = req_a[i*BITS +: BITS];
                sel_b  = req_b[i*BITS +: BITS];
                sel_op = req_op[i];
            end
        end
    end

    assign sum_p1 = addsub(a_p1, b_p1, op_p1);

    // FSM state register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: fixed walk through GRANT and EXEC, wait in RESP for the owner.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_valid) state_d = GRANT;
            GRANT:   state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are decoded from state so reset clears them at once.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        busy      = (state_q != IDLE);
        if (state_q == GRANT) req_ready = owner_oh;
        if (state_q == RESP)  rsp_valid = owner_oh;
    end

    // Arbitration: capture the winner in IDLE, advance the pointer on response accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_p0 <= '0;
            rr_ptr   <= '0;
        end else begin
            if (state_q == IDLE && any_valid) begin
                owner_p0 <= pick_idx;
            end
            if (state_q == RESP && rsp_accept) begin
                rr_ptr <= next_idx(owner_p0);
            end
        end
    end

    // GRANT -> EXEC boundary: latch the owner's operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_p1  <= '0;
            b_p1  <= '0;
            op_p1 <= 1'b0;
        end else if (state_q == GRANT) begin
            a_p1  <= sel_a;
            b_p1  <= sel_b;
            op_p1 <= sel_op;
        end
    end

    // EXEC -> RESP boundary: register the result; it holds through backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_y  <= '0;
            rsp_cb <= 1'b0;
        end else if (state_q == EXEC) begin
            rsp_y  <= sum_p1[BITS-1:0];
            rsp_cb <= sum_p1[BITS];
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [15:0] gcnt [NREQ];
    logic        stall_now;

    assign stall_now = any_valid && (state_q != IDLE);

    // Saturating per-requester grant counters, bumped once per GRANT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                gcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (state_q == GRANT && owner_p0 == IDXW'(i) && gcnt[i] != 16'hFFFF) begin
                    gcnt[i] <= gcnt[i] + 16'd1;
                end
            end
        end
    end

    // Saturating count of cycles where a request waits because the block is busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall_now && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    // Pack the counters onto the flat output bus.
    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant_cnt[i*16 +: 16] = gcnt[i];
        end
    end
`endif

endmodule
